rename_table_ckpt: RTL and testbench
====================================

Name: rename_table_ckpt

Overview:
- Parametrised successor to the architectural register file / register alias table of the Tomasulo core.
- Holds the architectural values and per-register busy bits with ROB-tag renames.
- Serves one decode rename request per cycle with two source operands and one destination.
- Accepts NCOMMIT commit broadcasts per cycle.
- Adds branch checkpoints: snapshot, selective restore and release, so a mispredict no longer requires a full flush.

Parameters:
NREG, 32, number of architectural registers; register 0 is hard-wired to zero.
XLEN, 32, data width.
TAG_W, 4, ROB tag width.
NCOMMIT, 2, commit ports per cycle; a higher port index is a younger instruction.
NCKPT, 4, number of checkpoint slots.
(Derived: RI_W = $clog2(NREG), CK_W = $clog2(NCKPT).)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rdy  in  1  global ready; when 0, all state and outputs hold
commit_valid  in  NCOMMIT  per-port commit strobe
commit_rd  in  NCOMMIT*RI_W  destination register per port
commit_data  in  NCOMMIT*XLEN  result per port
commit_tag  in  NCOMMIT*TAG_W  ROB tag per port
rename_valid  in  1  rename request
rename_id  in  TAG_W  requester id, echoed back
rs1_en, rs2_en  in  1 each  source operand used
rs1, rs2  in  RI_W each  source register index
rd_en  in  1  destination written (0 for branch/store)
rd  in  RI_W  destination register index
rd_tag  in  TAG_W  ROB tag of the new instruction
ckpt_take  in  1  take a snapshot with this rename
ckpt_release_valid  in  1  free a slot (branch resolved correct)
ckpt_release_id  in  CK_W  slot to free
restore_valid  in  1  mispredict recovery
restore_id  in  CK_W  slot to restore
restore_kill_mask  in  NCKPT  slots to free on restore (younger branches)
flush_all  in  1  full flush
rename_done  out  1  one-cycle pulse: operand outputs valid
rename_done_id  out  TAG_W  echoed rename_id
op1_busy, op2_busy  out  1 each  operand pending
op1_tag, op2_tag  out  TAG_W each  producer tag when busy
op1_data, op2_data  out  XLEN each  value when not busy
ckpt_slot  out  CK_W  slot allocated, valid with rename_done
ckpt_full  out  1  combinational: no free slot
ckpt_err  out  1  one-cycle pulse: ckpt_take while full

Behaviour:
- Reset (async, rst_n=0):
  - All values, busy bits and tags cleared to 0; all checkpoint slots free.
  - All outputs 0; ckpt_full=0.
- Priority each rdy cycle: flush_all > restore_valid > rename_valid.
  - A rename in a flush or restore cycle is dropped; rename_done=0 next cycle.
- Commit (every rdy cycle, including flush and restore cycles):
  - For each valid port with rd≠0, write commit_data to value[rd].
  - Same rd on several ports: the highest index wins.
  - busy[rd] clears only if commit_tag == tag[rd].
  - Tag-matching busy bits are also cleared in every allocated snapshot.
  - Writes to register 0 are ignored.
- Rename (1-cycle latency; outputs registered, rename_done pulses for one cycle):
  - Operand with en=0 or index 0: busy=0, data=0.
  - Register busy and a same-cycle commit matches (rd, tag): busy=0, data = commit data (bypass).
  - Register busy, no matching commit: busy=1, tag=tag[rs].
  - Register not busy: busy=0, data = value with same-cycle commit data bypassed.
  - Sources read the mapping before this rename's destination update, so rs==rd sees the old mapping.
  - If rd_en and rd≠0: busy[rd]=1, tag[rd]=rd_tag. This overrides a same-cycle commit clear on that rd.
- Checkpoint take:
  - On rename with ckpt_take and a free slot: allocate the lowest free slot.
  - The snapshot of busy/tag tables includes this rename's destination update and same-cycle commit clears.
  - ckpt_slot = allocated slot, output with rename_done.
  - When full: no snapshot, ckpt_err pulses, the rename still completes.
- Release: frees slot ckpt_release_id. Releasing a free slot has no effect. Release and allocation in the same cycle are allowed; the freed slot is not reused until the next cycle.
- Restore:
  - busy/tag tables are replaced from slot restore_id, with same-cycle commit clears applied.
  - Values are untouched.
  - Frees restore_id and every slot set in restore_kill_mask.
  - Restoring a free slot is ignored.
- flush_all: all busy bits cleared, all slots freed, rename_done=0 next cycle.
- rdy=0: no state change; commits are not applied; outputs hold.
- Reset asserted mid-operation: immediate clear, no partial state retained.

Test Plan:
- Reset, then rename rs1=5, rs2=0 -> next cycle rename_done=1, op1_busy=0, op1_data=0, op2_busy=0.
- Rename rd=3 tag=7; then rename rs1=3 -> op1_busy=1, op1_tag=7. In the same cycle commit rd=3 tag=7 data=0xDEAD -> op1_busy=0, op1_data=0xDEAD (bypass).
- Commits on port0 and port1 both to rd=4, data 1 and 2 -> value[4]=2. A commit with a stale tag writes the value but leaves busy set.
- Rename rd=8 tag=2 with ckpt_take -> ckpt_slot=0. Rename rd=8 tag=5. Commit tag=2. restore_valid id=0 -> a read of r8 gives busy=0 and the committed value. ckpt_full=0.
- Take 4 checkpoints -> ckpt_full=1. A fifth ckpt_take -> ckpt_err=1 and rename_done=1. restore id=1 with kill_mask=0b1100 -> only slot 0 remains allocated.
- Drop rdy for 3 cycles with commit_valid=1 -> no state change. flush_all together with rename -> rename_done=0, all busy bits 0, ckpt_full=0.

Source files
------------

// File: rtl/rename_table_ckpt.sv
// Register alias table with architectural values, per-register busy/tag
// renames, multi-port commit and branch checkpoints (snapshot, selective
// restore, release).
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   rdy                 global ready; all state and outputs hold when low
//   commit_*            NCOMMIT commit broadcasts (higher index = younger)
//   rename_* / rs* / rd* one rename request per cycle (2 sources, 1 dest)
//   ckpt_take           snapshot the busy/tag tables with this rename
//   ckpt_release_*      free a checkpoint slot
//   restore_*           mispredict recovery from a slot, killing younger slots
//   flush_all           clear all busy bits and checkpoint slots
//   rename_done, op*_*, ckpt_slot, ckpt_err   registered rename results
//   ckpt_full           combinational: no free checkpoint slot
module rename_table_ckpt #(
  parameter int unsigned NREG    = 32,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned NCOMMIT = 2,
  parameter int unsigned NCKPT   = 4,
  localparam int unsigned RI_W   = $clog2(NREG),
  localparam int unsigned CK_W   = $clog2(NCKPT)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rdy,
  input  logic [NCOMMIT-1:0]       commit_valid,
  input  logic [NCOMMIT*RI_W-1:0]  commit_rd,
  input  logic [NCOMMIT*XLEN-1:0]  commit_data,
  input  logic [NCOMMIT*TAG_W-1:0] commit_tag,
  input  logic                     rename_valid,
  input  logic [TAG_W-1:0]         rename_id,
  input  logic                     rs1_en,
  input  logic                     rs2_en,
  input  logic [RI_W-1:0]          rs1,
  input  logic [RI_W-1:0]          rs2,
  input  logic                     rd_en,
  input  logic [RI_W-1:0]          rd,
  input  logic [TAG_W-1:0]         rd_tag,
  input  logic                     ckpt_take,
  input  logic                     ckpt_release_valid,
  input  logic [CK_W-1:0]          ckpt_release_id,
  input  logic                     restore_valid,
  input  logic [CK_W-1:0]          restore_id,
  input  logic [NCKPT-1:0]         restore_kill_mask,
  input  logic                     flush_all,
  output logic                     rename_done,
  output logic [TAG_W-1:0]         rename_done_id,
  output logic                     op1_busy,
  output logic                     op2_busy,
  output logic [TAG_W-1:0]         op1_tag,
  output logic [TAG_W-1:0]         op2_tag,
  output logic [XLEN-1:0]          op1_data,
  output logic [XLEN-1:0]          op2_data,
  output logic [CK_W-1:0]          ckpt_slot,
  output logic                     ckpt_full,
  output logic                     ckpt_err
);

  typedef struct packed {
    logic             busy;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  data;
  } op_t;

  // Architectural state and snapshots
  logic [XLEN-1:0]  val_q   [NREG];
  logic [NREG-1:0]  busy_q;
  logic [TAG_W-1:0] tag_q   [NREG];
  logic [NREG-1:0]  sbusy_q [NCKPT];
  logic [TAG_W-1:0] stag_q  [NCKPT][NREG];
  logic [NCKPT-1:0] svalid_q;

  logic [NREG-1:0]  busy_d;
  logic [TAG_W-1:0] tag_d   [NREG];
  logic [NREG-1:0]  sbusy_d [NCKPT];
  logic [TAG_W-1:0] stag_d  [NCKPT][NREG];
  logic [NCKPT-1:0] svalid_d;

  logic [NREG-1:0]  busy_ren;
  logic [TAG_W-1:0] tag_ren [NREG];

  // Unpacked commit ports
  logic [RI_W-1:0]  c_rd   [NCOMMIT];
  logic [XLEN-1:0]  c_data [NCOMMIT];
  logic [TAG_W-1:0] c_tag  [NCOMMIT];
  logic [NCOMMIT-1:0] c_we;

  always_comb begin
    c_we = '0;
    for (int unsigned p = 0; p < NCOMMIT; p++) begin
      c_rd[p]   = commit_rd[p*RI_W +: RI_W];
      c_data[p] = commit_data[p*XLEN +: XLEN];
      c_tag[p]  = commit_tag[p*TAG_W +: TAG_W];
      c_we[p]   = commit_valid[p] && (c_rd[p] != '0);
    end
  end

  // Commit effects: values after write (youngest port wins) and busy clears
  logic [XLEN-1:0] val_c  [NREG];
  logic [NREG-1:0] clr_c;
  logic [NREG-1:0] sclr_c [NCKPT];

  always_comb begin
    clr_c = '0;
    for (int unsigned r = 0; r < NREG; r++) val_c[r] = val_q[r];
    for (int unsigned s = 0; s < NCKPT; s++) sclr_c[s] = '0;
    for (int unsigned p = 0; p < NCOMMIT; p++) begin
      if (c_we[p]) begin
        val_c[c_rd[p]] = c_data[p];
        if (c_tag[p] == tag_q[c_rd[p]]) clr_c[c_rd[p]] = 1'b1;
        for (int unsigned s = 0; s < NCKPT; s++) begin
          if (c_tag[p] == stag_q[s][c_rd[p]]) sclr_c[s][c_rd[p]] = 1'b1;
        end
      end
    end
  end

  // Source operand read: old mapping, with same-cycle commit bypass
  function automatic op_t read_op(input logic en, input logic [RI_W-1:0] rs);
    op_t o;
    o = '0;
    if (en && rs != '0) begin
      if (busy_q[rs] && !clr_c[rs]) begin
        o.busy = 1'b1;
        o.tag  = tag_q[rs];
      end else begin
        o.data = val_c[rs];
      end
    end
    return o;
  endfunction

  op_t op1_c, op2_c;
  always_comb begin
    op1_c = read_op(rs1_en, rs1);
    op2_c = read_op(rs2_en, rs2);
  end

  // Lowest free checkpoint slot
  logic            any_free;
  logic [CK_W-1:0] free_slot;
  always_comb begin
    any_free  = 1'b0;
    free_slot = '0;
    for (int i = int'(NCKPT) - 1; i >= 0; i--) begin
      if (!svalid_q[i]) begin
        any_free  = 1'b1;
        free_slot = CK_W'(i);
      end
    end
  end

  assign ckpt_full = &svalid_q;

  logic do_rename, do_take, take_err, restore_ok;
  always_comb begin
    do_rename  = rename_valid && !flush_all && !restore_valid;
    do_take    = do_rename && ckpt_take && any_free;
    take_err   = do_rename && ckpt_take && !any_free;
    restore_ok = !flush_all && restore_valid && svalid_q[restore_id];
  end

  // Next busy/tag tables and snapshot bookkeeping
  always_comb begin
    busy_ren = busy_q & ~clr_c;
    for (int unsigned r = 0; r < NREG; r++) tag_ren[r] = tag_q[r];
    // Destination rename overrides a same-cycle commit clear
    if (do_rename && rd_en && rd != '0) begin
      busy_ren[rd] = 1'b1;
      tag_ren[rd]  = rd_tag;
    end

    busy_d = busy_ren;
    for (int unsigned r = 0; r < NREG; r++) tag_d[r] = tag_ren[r];
    if (flush_all) begin
      busy_d = '0;
    end else if (restore_ok) begin
      busy_d = sbusy_q[restore_id] & ~sclr_c[restore_id];
      for (int unsigned r = 0; r < NREG; r++) tag_d[r] = stag_q[restore_id][r];
    end

    // Release frees at the edge; allocation only sees the current free set
    svalid_d = svalid_q;
    if (ckpt_release_valid) svalid_d = svalid_d & ~(NCKPT'(1) << ckpt_release_id);
    if (flush_all) begin
      svalid_d = '0;
    end else if (restore_ok) begin
      svalid_d = svalid_d & ~restore_kill_mask & ~(NCKPT'(1) << restore_id);
    end else if (do_take) begin
      svalid_d[free_slot] = 1'b1;
    end

    for (int unsigned s = 0; s < NCKPT; s++) begin
      sbusy_d[s] = sbusy_q[s] & ~sclr_c[s];
      for (int unsigned r = 0; r < NREG; r++) stag_d[s][r] = stag_q[s][r];
    end
    if (do_take) begin
      sbusy_d[free_slot] = busy_ren;
      for (int unsigned r = 0; r < NREG; r++) stag_d[free_slot][r] = tag_ren[r];
    end
  end

  // Table state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= '0;
      svalid_q <= '0;
      for (int unsigned r = 0; r < NREG; r++) begin
        val_q[r] <= '0;
        tag_q[r] <= '0;
      end
      for (int unsigned s = 0; s < NCKPT; s++) begin
        sbusy_q[s] <= '0;
        for (int unsigned r = 0; r < NREG; r++) stag_q[s][r] <= '0;
      end
    end else if (rdy) begin
      busy_q   <= busy_d;
      svalid_q <= svalid_d;
      for (int unsigned r = 0; r < NREG; r++) begin
        val_q[r] <= val_c[r];
        tag_q[r] <= tag_d[r];
      end
      for (int unsigned s = 0; s < NCKPT; s++) begin
        sbusy_q[s] <= sbusy_d[s];
        for (int unsigned r = 0; r < NREG; r++) stag_q[s][r] <= stag_d[s][r];
      end
    end
  end

  // Registered rename results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rename_done    <= 1'b0;
      rename_done_id <= '0;
      op1_busy       <= 1'b0;
      op2_busy       <= 1'b0;
      op1_tag        <= '0;
      op2_tag        <= '0;
      op1_data       <= '0;
      op2_data       <= '0;
      ckpt_slot      <= '0;
      ckpt_err       <= 1'b0;
    end else if (rdy) begin
      rename_done <= do_rename;
      ckpt_err    <= take_err;
      if (do_rename) begin
        rename_done_id <= rename_id;
        op1_busy       <= op1_c.busy;
        op1_tag        <= op1_c.tag;
        op1_data       <= op1_c.data;
        op2_busy       <= op2_c.busy;
        op2_tag        <= op2_c.tag;
        op2_data       <= op2_c.data;
      end
      if (do_take) ckpt_slot <= free_slot;
    end
  end

endmodule

// File: tb/tb_rename_table_ckpt.sv
// Vector bench for rename_table_ckpt: each record drives one cycle and
// holds the outputs expected just after that cycle's clock edge.
module tb_rename_table_ckpt;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic [1:0]  commit_valid;
  logic [9:0]  commit_rd;
  logic [63:0] commit_data;
  logic [7:0]  commit_tag;
  logic        rename_valid;
  logic [3:0]  rename_id;
  logic        rs1_en, rs2_en;
  logic [4:0]  rs1, rs2;
  logic        rd_en;
  logic [4:0]  rd;
  logic [3:0]  rd_tag;
  logic        ckpt_take;
  logic        ckpt_release_valid;
  logic [1:0]  ckpt_release_id;
  logic        restore_valid;
  logic [1:0]  restore_id;
  logic [3:0]  restore_kill_mask;
  logic        flush_all;
  logic        rename_done;
  logic [3:0]  rename_done_id;
  logic        op1_busy, op2_busy;
  logic [3:0]  op1_tag, op2_tag;
  logic [31:0] op1_data, op2_data;
  logic [1:0]  ckpt_slot;
  logic        ckpt_full;
  logic        ckpt_err;

  rename_table_ckpt dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .commit_valid(commit_valid), .commit_rd(commit_rd),
    .commit_data(commit_data), .commit_tag(commit_tag),
    .rename_valid(rename_valid), .rename_id(rename_id),
    .rs1_en(rs1_en), .rs2_en(rs2_en), .rs1(rs1), .rs2(rs2),
    .rd_en(rd_en), .rd(rd), .rd_tag(rd_tag),
    .ckpt_take(ckpt_take),
    .ckpt_release_valid(ckpt_release_valid), .ckpt_release_id(ckpt_release_id),
    .restore_valid(restore_valid), .restore_id(restore_id),
    .restore_kill_mask(restore_kill_mask), .flush_all(flush_all),
    .rename_done(rename_done), .rename_done_id(rename_done_id),
    .op1_busy(op1_busy), .op2_busy(op2_busy),
    .op1_tag(op1_tag), .op2_tag(op2_tag),
    .op1_data(op1_data), .op2_data(op2_data),
    .ckpt_slot(ckpt_slot), .ckpt_full(ckpt_full), .ckpt_err(ckpt_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rdy, flush, rn, e1, e2, de, tk;
    logic [4:0]  s1, s2, d;
    logic [3:0]  t, rid;
    logic [1:0]  cv;
    logic [4:0]  crd0, crd1;
    logic [31:0] cd0, cd1;
    logic [3:0]  ct0, ct1;
    logic        rel;
    logic [1:0]  rel_id;
    logic        rs;
    logic [1:0]  rs_id;
    logic [3:0]  kill;
    logic        e_done, e_ops, e_b1, e_b2, e_schk, e_full, e_err;
    logic [3:0]  e_t1, e_t2, e_id;
    logic [31:0] e_d1, e_d2;
    logic [1:0]  e_slot;
  } vec_t;

  vec_t vq[$];
  int   ntests = 0;
  int   nfail  = 0;

  function automatic vec_t idle();
    vec_t v;
    v = '0;
    v.rdy = 1'b1;
    return v;
  endfunction

  function automatic vec_t ren(input logic e1, input logic [4:0] s1,
                               input logic e2, input logic [4:0] s2,
                               input logic de, input logic [4:0] d,
                               input logic [3:0] t, input logic tk);
    vec_t v;
    v = idle();
    v.rn = 1'b1; v.e1 = e1; v.s1 = s1; v.e2 = e2; v.s2 = s2;
    v.de = de; v.d = d; v.t = t; v.tk = tk;
    v.e_done = 1'b1; v.e_ops = 1'b1;
    return v;
  endfunction

  function automatic vec_t cmt(input vec_t vi, input int p, input logic [4:0] r,
                               input logic [31:0] dt, input logic [3:0] t);
    vec_t v;
    v = vi;
    if (p == 0) begin v.cv[0] = 1'b1; v.crd0 = r; v.cd0 = dt; v.ct0 = t; end
    else        begin v.cv[1] = 1'b1; v.crd1 = r; v.cd1 = dt; v.ct1 = t; end
    return v;
  endfunction

  function automatic vec_t ex(input vec_t vi,
                              input logic b1, input logic [3:0] t1, input logic [31:0] d1,
                              input logic b2, input logic [3:0] t2, input logic [31:0] d2);
    vec_t v;
    v = vi;
    v.e_b1 = b1; v.e_t1 = t1; v.e_d1 = d1;
    v.e_b2 = b2; v.e_t2 = t2; v.e_d2 = d2;
    return v;
  endfunction

  function automatic vec_t slot(input vec_t vi, input logic [1:0] s, input logic full);
    vec_t v;
    v = vi;
    v.e_schk = 1'b1; v.e_slot = s; v.e_full = full;
    return v;
  endfunction

  task automatic add(input vec_t vin);
    vec_t v;
    v = vin;
    v.rid = 4'(vq.size());
    if (v.rdy && v.e_done) v.e_id = v.rid;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rdy                = v.rdy;
    flush_all          = v.flush;
    rename_valid       = v.rn;
    rename_id          = v.rid;
    rs1_en             = v.e1;
    rs1                = v.s1;
    rs2_en             = v.e2;
    rs2                = v.s2;
    rd_en              = v.de;
    rd                 = v.d;
    rd_tag             = v.t;
    ckpt_take          = v.tk;
    commit_valid       = v.cv;
    commit_rd          = {v.crd1, v.crd0};
    commit_data        = {v.cd1, v.cd0};
    commit_tag         = {v.ct1, v.ct0};
    ckpt_release_valid = v.rel;
    ckpt_release_id    = v.rel_id;
    restore_valid      = v.rs;
    restore_id         = v.rs_id;
    restore_kill_mask  = v.kill;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    chk($sformatf("v%0d.done", i), 32'(rename_done), 32'(v.e_done));
    chk($sformatf("v%0d.err", i), 32'(ckpt_err), 32'(v.e_err));
    chk($sformatf("v%0d.full", i), 32'(ckpt_full), 32'(v.e_full));
    if (v.e_done) chk($sformatf("v%0d.id", i), 32'(rename_done_id), 32'(v.e_id));
    if (v.e_ops) begin
      chk($sformatf("v%0d.op1_busy", i), 32'(op1_busy), 32'(v.e_b1));
      if (v.e_b1) chk($sformatf("v%0d.op1_tag", i), 32'(op1_tag), 32'(v.e_t1));
      else        chk($sformatf("v%0d.op1_data", i), op1_data, v.e_d1);
      chk($sformatf("v%0d.op2_busy", i), 32'(op2_busy), 32'(v.e_b2));
      if (v.e_b2) chk($sformatf("v%0d.op2_tag", i), 32'(op2_tag), 32'(v.e_t2));
      else        chk($sformatf("v%0d.op2_data", i), op2_data, v.e_d2);
    end
    if (v.e_schk) chk($sformatf("v%0d.slot", i), 32'(ckpt_slot), 32'(v.e_slot));
  endtask

  initial begin
    vec_t v;
    vec_t h;

    // ---- vector table ----
    add(ren(1, 5, 1, 0, 0, 0, 0, 0));                                   // 0
    add(ren(0, 0, 0, 0, 1, 3, 7, 0));                                   // 1 rd3<-tag7
    add(ex(ren(1, 3, 0, 0, 0, 0, 0, 0), 1, 7, 0, 0, 0, 0));             // 2 busy
    add(ex(cmt(ren(1, 3, 0, 0, 0, 0, 0, 0), 0, 3, 32'hDEAD, 7),
           0, 0, 32'hDEAD, 0, 0, 0));                                   // 3 bypass
    v = idle(); v = cmt(v, 0, 4, 32'd1, 4'd1); v = cmt(v, 1, 4, 32'd2, 4'd2);
    add(v);                                                             // 4 both ports rd4
    add(ex(ren(1, 4, 0, 0, 0, 0, 0, 0), 0, 0, 32'd2, 0, 0, 0));         // 5 value[4]=2
    add(ex(ren(1, 4, 0, 0, 1, 4, 9, 0), 0, 0, 32'd2, 0, 0, 0));         // 6 rs==rd old map
    add(ex(cmt(ren(1, 4, 0, 0, 0, 0, 0, 0), 0, 4, 32'h33, 3),
           1, 9, 0, 0, 0, 0));                                          // 7 stale tag
    add(ex(ren(0, 0, 1, 4, 0, 0, 0, 0), 0, 0, 0, 1, 9, 0));             // 8 still busy
    add(ex(cmt(ren(0, 0, 1, 4, 0, 0, 0, 0), 1, 4, 32'h99, 9),
           0, 0, 0, 0, 0, 32'h99));                                     // 9 port1 bypass
    add(ex(cmt(ren(1, 6, 0, 0, 0, 0, 0, 0), 0, 6, 32'h66, 0),
           0, 0, 32'h66, 0, 0, 0));                                     // 10 idle-reg bypass
    add(cmt(ren(1, 0, 0, 3, 0, 0, 0, 0), 0, 0, 32'hFF, 0));             // 11 r0 / en=0
    add(slot(ren(0, 0, 0, 0, 1, 8, 2, 1), 2'd0, 0));                    // 12 ckpt slot0
    add(ren(0, 0, 0, 0, 1, 8, 5, 0));                                   // 13 rd8<-tag5
    add(cmt(idle(), 0, 8, 32'h88, 2));                                  // 14 commit tag2
    v = idle(); v.rs = 1'b1; v.rs_id = 2'd0;
    add(v);                                                             // 15 restore 0
    add(ex(ren(1, 8, 0, 0, 0, 0, 0, 0), 0, 0, 32'h88, 0, 0, 0));        // 16 r8 free
    add(slot(ren(0, 0, 0, 0, 1, 11, 1, 1), 2'd0, 0));                   // 17
    add(slot(ren(0, 0, 0, 0, 1, 12, 2, 1), 2'd1, 0));                   // 18
    add(slot(ren(0, 0, 0, 0, 1, 13, 3, 1), 2'd2, 0));                   // 19
    add(slot(ren(0, 0, 0, 0, 1, 14, 4, 1), 2'd3, 1));                   // 20 full
    v = ren(0, 0, 0, 0, 1, 15, 5, 1); v.e_full = 1'b1; v.e_err = 1'b1;
    add(v);                                                             // 21 take while full
    v = ren(0, 0, 0, 0, 1, 20, 6, 0); v.e_done = 1'b0; v.e_ops = 1'b0;
    v.rs = 1'b1; v.rs_id = 2'd1; v.kill = 4'b1100;
    add(v);                                                             // 22 restore 1, rename dropped
    add(ex(ren(1, 13, 1, 12, 0, 0, 0, 0), 0, 0, 0, 1, 2, 0));           // 23
    add(ex(ren(1, 20, 1, 11, 0, 0, 0, 0), 0, 0, 0, 1, 1, 0));           // 24
    add(slot(ren(0, 0, 0, 0, 0, 0, 0, 1), 2'd1, 0));                    // 25 slot0 still held
    add(slot(ren(0, 0, 0, 0, 0, 0, 0, 1), 2'd2, 0));                    // 26
    add(slot(ren(0, 0, 0, 0, 0, 0, 0, 1), 2'd3, 1));                    // 27
    v = ren(0, 0, 0, 0, 0, 0, 0, 1); v.rel = 1'b1; v.rel_id = 2'd1; v.e_err = 1'b1;
    add(v);                                                             // 28 release+take same cycle
    h = slot(ex(ren(1, 3, 0, 0, 0, 0, 0, 1), 0, 0, 32'hDEAD, 0, 0, 0), 2'd1, 1);
    add(h);                                                             // 29
    h = vq[29];
    h.rdy = 1'b0; h.s1 = 5'd4;
    h = cmt(h, 0, 3, 32'h1313, 0);
    for (int k = 0; k < 3; k++) add(h);                                 // 30-32 rdy low holds
    v = ex(ren(1, 3, 0, 0, 0, 0, 0, 0), 0, 0, 32'hDEAD, 0, 0, 0); v.e_full = 1'b1;
    add(v);                                                             // 33 commit not applied
    v = ren(1, 11, 0, 0, 0, 0, 0, 0); v.flush = 1'b1; v.e_done = 1'b0; v.e_ops = 1'b0;
    add(v);                                                             // 34 flush
    add(ren(1, 11, 1, 12, 0, 0, 0, 0));                                 // 35 nothing busy
    add(slot(ren(0, 0, 0, 0, 0, 0, 0, 1), 2'd0, 0));                    // 36 all slots freed

    // ---- reset ----
    drive(idle());
    rst_n = 1'b0;
    #12;
    chk("reset.done", 32'(rename_done), 32'd0);
    chk("reset.full", 32'(ckpt_full), 32'd0);
    chk("reset.op1_data", op1_data, 32'd0);
    chk("reset.slot", 32'(ckpt_slot), 32'd0);
    rst_n = 1'b1;

    // ---- table ----
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i]);
      @(posedge clk);
      #1;
      check_vec(i, vq[i]);
    end

    // ---- asynchronous reset mid-operation ----
    v = cmt(ren(1, 3, 0, 0, 1, 20, 6, 0), 0, 21, 32'h21, 0);
    v.rid = 4'hA;
    drive(v);
    @(posedge clk);
    #1;
    chk("midrst.pre_done", 32'(rename_done), 32'd1);
    chk("midrst.pre_data", op1_data, 32'hDEAD);
    drive(idle());
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.done", 32'(rename_done), 32'd0);
    chk("midrst.id", 32'(rename_done_id), 32'd0);
    chk("midrst.op1_data", op1_data, 32'd0);
    #3;
    rst_n = 1'b1;
    drive(ren(1, 21, 1, 20, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    chk("midrst.r21_data", op1_data, 32'd0);
    chk("midrst.r20_busy", 32'(op2_busy), 32'd0);
    chk("midrst.done2", 32'(rename_done), 32'd1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
